// File: rtl/txt_pkg.sv
// Shared constants, character codes and FSM encoding for the text-mode
// display memory writer.
package txt_pkg;

  localparam int COLS         = 40;
  localparam int ROWS         = 30;
  localparam int ADDR_W       = 12;
  localparam int CELLS        = COLS * ROWS;
  localparam int SCROLL_CELLS = COLS * (ROWS - 1);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;

  localparam logic [5:0]        X_LAST      = 6'(COLS - 1);
  localparam logic [4:0]        Y_LAST      = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_OFS     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] SCROLL_BASE = ADDR_W'(SCROLL_CELLS);
  localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'(SCROLL_CELLS - 1);
  localparam logic [ADDR_W-1:0] CELLS_LAST  = ADDR_W'(CELLS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_CLR_ROW,
    ST_CLR_ALL
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/txt_addr_calc.sv
// Cell address of (row, col) in the 40-column grid: row*40 + col,
// written as shifts so it matches the renderer's layout formula.
module txt_addr_calc
  import txt_pkg::*;
(
  input  logic [4:0]        i_row,
  input  logic [5:0]        i_col,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  assign w_row  = {{(ADDR_W-5){1'b0}}, i_row};
  assign w_col  = {{(ADDR_W-6){1'b0}}, i_col};
  assign o_addr = (w_row << 5) + (w_row << 3) + w_col;

endmodule

// File: rtl/txt_writer.sv
// Byte-stream writer for the 40x30 text display memory: places characters,
// tracks the cursor, handles CR/LF/BS/FF and scrolls by copying rows up.
module txt_writer
  import txt_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_en,
  input  logic [7:0]        mem_rdata,
  output logic [5:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              busy
);

  state_t            r_state, w_state_next;
  logic [5:0]        r_x, w_x_next;
  logic [4:0]        r_y, w_y_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_waddr, w_waddr_next;
  logic [7:0]        r_wdata, w_wdata_next;
  logic              r_adv, w_adv_next;

  logic              w_accept;
  logic [5:0]        w_bs_x, w_tgt_x;
  logic [4:0]        w_bs_y, w_tgt_y;
  logic [ADDR_W-1:0] w_tgt_addr;

  assign char_ready = (r_state == ST_IDLE) && !clr;
  assign w_accept   = char_valid && char_ready;

  // Backspace target: step left, wrapping to the end of the previous row.
  always_comb begin
    w_bs_x = r_x;
    w_bs_y = r_y;
    if (r_x != 6'd0) begin
      w_bs_x = r_x - 6'd1;
    end else if (r_y != 5'd0) begin
      w_bs_x = X_LAST;
      w_bs_y = r_y - 5'd1;
    end
  end

  assign w_tgt_x = (char_in == CH_BS) ? w_bs_x : r_x;
  assign w_tgt_y = (char_in == CH_BS) ? w_bs_y : r_y;

  txt_addr_calc u_addr_calc (
    .i_row  (w_tgt_y),
    .i_col  (w_tgt_x),
    .o_addr (w_tgt_addr)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_adv   <= 1'b0;
    end else begin
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_cnt   <= w_cnt_next;
      r_waddr <= w_waddr_next;
      r_wdata <= w_wdata_next;
      r_adv   <= w_adv_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_cnt_next   = r_cnt;
    w_waddr_next = r_waddr;
    w_wdata_next = r_wdata;
    w_adv_next   = r_adv;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_printable(char_in)) begin
            w_state_next = ST_WRITE;
            w_waddr_next = w_tgt_addr;
            w_wdata_next = char_in;
            w_adv_next   = 1'b1;
          end else begin
            case (char_in)
              CH_CR: w_x_next = 6'd0;
              CH_LF: begin
                w_x_next = 6'd0;
                if (r_y != Y_LAST) begin
                  w_y_next = r_y + 5'd1;
                end else begin
                  w_state_next = ST_SCROLL_RD;
                  w_cnt_next   = '0;
                end
              end
              CH_BS: begin
                if ((r_x != 6'd0) || (r_y != 5'd0)) begin
                  w_x_next     = w_bs_x;
                  w_y_next     = w_bs_y;
                  w_waddr_next = w_tgt_addr;
                  w_wdata_next = CH_SPACE;
                  w_adv_next   = 1'b0;
                  w_state_next = ST_WRITE;
                end
              end
              CH_FF: begin
                w_state_next = ST_CLR_ALL;
                w_cnt_next   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      ST_WRITE: begin
        w_state_next = ST_IDLE;
        if (r_adv) begin
          if (r_x != X_LAST) begin
            w_x_next = r_x + 6'd1;
          end else begin
            w_x_next = 6'd0;
            if (r_y != Y_LAST) begin
              w_y_next = r_y + 5'd1;
            end else begin
              w_state_next = ST_SCROLL_RD;
              w_cnt_next   = '0;
            end
          end
        end
      end
      ST_SCROLL_RD: w_state_next = ST_SCROLL_WR;
      ST_SCROLL_WR: begin
        if (r_cnt == SCROLL_LAST) begin
          w_state_next = ST_CLR_ROW;
          w_cnt_next   = SCROLL_BASE;
        end else begin
          w_state_next = ST_SCROLL_RD;
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      ST_CLR_ROW: begin
        if (r_cnt == CELLS_LAST) begin
          w_state_next = ST_IDLE;
          w_x_next     = 6'd0;
          w_y_next     = Y_LAST;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_CLR_ALL: begin
        if (r_cnt == CELLS_LAST) begin
          w_state_next = ST_IDLE;
          w_x_next     = 6'd0;
          w_y_next     = 5'd0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Scroll write data passes straight through from the read issued one cycle earlier.
  always_comb begin
    mem_we    = 1'b0;
    mem_en    = (r_state != ST_IDLE);
    mem_addr  = r_waddr;
    mem_wdata = r_wdata;
    case (r_state)
      ST_WRITE: mem_we = 1'b1;
      ST_SCROLL_RD: mem_addr = r_cnt + ROW_OFS;
      ST_SCROLL_WR: begin
        mem_we    = 1'b1;
        mem_addr  = r_cnt;
        mem_wdata = mem_rdata;
      end
      ST_CLR_ROW, ST_CLR_ALL: begin
        mem_we    = 1'b1;
        mem_addr  = r_cnt;
        mem_wdata = CH_SPACE;
      end
      default: ;
    endcase
  end

  assign cursor_x = r_x;
  assign cursor_y = r_y;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_txt_writer.sv
// Directed bench for txt_writer: table of single-byte vectors plus
// hand-written scroll, clear-screen and mid-scroll reset sequences.
module tb_txt_writer;
  import txt_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_en;
  logic [7:0]  mem_rdata = 8'h00;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  always #5 clk = ~clk;

  txt_writer dut (
    .clk        (clk),
    .clr        (clr),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_en     (mem_en),
    .mem_rdata  (mem_rdata),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  // Display memory model with one-cycle registered read.
  logic [7:0] tbmem [0:1199];
  logic [7:0] snap  [0:1199];
  int preload_kind = 0;

  function automatic logic [7:0] pattern(input int kind, input int i);
    if (kind == 1) return 8'(8'h21 + (i % 90));
    return 8'(8'h41 + (i % 26));
  endfunction

  always @(posedge clk) begin
    if (preload_kind != 0) begin
      for (int i = 0; i < 1200; i++) tbmem[i] <= pattern(preload_kind, i);
    end else if (mem_we && mem_addr < 12'd1200) begin
      tbmem[mem_addr] <= mem_wdata;
    end
    if (mem_en && mem_addr < 12'd1200) mem_rdata <= tbmem[mem_addr];
  end

  int range_err = 0;
  int idle_we_err = 0;
  always @(negedge clk) begin
    if (mem_en && mem_addr >= 12'd1200) range_err++;
    if (cursor_x > 6'd39 || cursor_y > 5'd29) range_err++;
    if (mem_we && !busy) idle_we_err++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Send one byte at a negedge and follow it until the block is idle again.
  task automatic send(input logic [7:0] b, output int we_n, output int la,
                      output int ld, output int busy_n);
    int guard;
    we_n = 0; la = -1; ld = -1; busy_n = 0;
    guard = 0;
    while (!char_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!char_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    char_in = b;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    guard = 0;
    while (busy && guard < 5000) begin
      if (mem_we) begin
        we_n++;
        la = int'(mem_addr);
        ld = int'(mem_wdata);
      end
      busy_n++;
      @(negedge clk);
      guard++;
    end
    if (busy) check("busy_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] ch;
    int we;
    int addr;
    int data;
    int x;
    int y;
    int busy;
  } vec_t;

  vec_t vt [25];

  task automatic apply_vec(input int idx);
    int we_n, la, ld, bn;
    vec_t v;
    v = vt[idx];
    send(v.ch, we_n, la, ld, bn);
    check($sformatf("v%0d_we_count", idx), we_n, v.we);
    if (v.we > 0) begin
      check($sformatf("v%0d_addr", idx), la, v.addr);
      check($sformatf("v%0d_wdata", idx), ld, v.data);
    end
    check($sformatf("v%0d_cursor_x", idx), int'(cursor_x), v.x);
    check($sformatf("v%0d_cursor_y", idx), int'(cursor_y), v.y);
    check($sformatf("v%0d_busy_cycles", idx), bn, v.busy);
    check($sformatf("v%0d_ready_after", idx), int'(char_ready), 1);
    $display("vec %0d: byte=0x%02h writes=%0d addr=%0d data=0x%0h cursor=(%0d,%0d) busy=%0d",
             idx, v.ch, we_n, la, ld, cursor_x, cursor_y, bn);
  endtask

  initial begin
    int we_n, la, ld, bn, bad, guard, found, late_we;

    vt[0]  = '{8'h41, 1, 0,   8'h41, 1,  0, 1};
    vt[1]  = '{8'h42, 1, 1,   8'h42, 2,  0, 1};
    vt[2]  = '{CH_CR, 0, 0,   0,     0,  0, 0};
    vt[3]  = '{CH_LF, 0, 0,   0,     0,  1, 0};
    vt[4]  = '{8'h07, 0, 0,   0,     0,  1, 0};
    vt[5]  = '{8'h43, 1, 40,  8'h43, 1,  1, 1};
    vt[6]  = '{CH_BS, 1, 40,  8'h20, 0,  1, 1};
    vt[7]  = '{CH_BS, 1, 39,  8'h20, 39, 0, 1};
    vt[8]  = '{8'h5A, 1, 39,  8'h5A, 0,  1, 1};
    vt[9]  = '{CH_LF, 0, 0,   0,     0,  2, 0};
    vt[10] = '{CH_BS, 1, 79,  8'h20, 39, 1, 1};
    vt[11] = '{CH_LF, 0, 0,   0,     0,  2, 0};
    vt[12] = '{8'h5A, 1, 119, 8'h5A, 0,  3, 1};
    vt[13] = '{8'h61, 1, 120, 8'h61, 1,  3, 1};
    vt[14] = '{8'h62, 1, 121, 8'h62, 2,  3, 1};
    vt[15] = '{8'h63, 1, 122, 8'h63, 3,  3, 1};
    vt[16] = '{8'h64, 1, 123, 8'h64, 4,  3, 1};
    vt[17] = '{8'h65, 1, 124, 8'h65, 5,  3, 1};
    vt[18] = '{CH_CR, 0, 0,   0,     0,  3, 0};
    vt[19] = '{CH_BS, 1, 119, 8'h20, 39, 2, 1};
    vt[20] = '{8'h07, 0, 0,   0,     39, 2, 0};
    vt[21] = '{CH_LF, 0, 0,   0,     0,  3, 0};
    vt[22] = '{CH_BS, 0, 0,   0,     0,  0, 0};
    vt[23] = '{8'h07, 0, 0,   0,     0,  0, 0};
    vt[24] = '{8'h41, 1, 0,   8'h41, 1,  0, 1};

    char_in = 8'h00;
    char_valid = 1'b0;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_en", int'(mem_en), 0);
    check("rst_cursor_x", int'(cursor_x), 0);
    check("rst_cursor_y", int'(cursor_y), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready_during_clr", int'(char_ready), 0);
    clr = 1'b0;
    #1;
    check("rst_ready_after_clr", int'(char_ready), 1);
    @(negedge clk);

    for (int i = 0; i <= 11; i++) apply_vec(i);

    // Fill row 2 up to column 39.
    for (int i = 0; i < 39; i++) send(8'h78, we_n, la, ld, bn);
    check("fill_row2_x", int'(cursor_x), 39);
    check("fill_row2_y", int'(cursor_y), 2);
    bad = 0;
    for (int i = 80; i < 119; i++) if (tbmem[i] != 8'h78) bad++;
    check("fill_row2_mem_bad", bad, 0);
    $display("fill row 2: cursor=(%0d,%0d) bad_cells=%0d", cursor_x, cursor_y, bad);

    for (int i = 12; i <= 21; i++) apply_vec(i);

    // Clear screen over a non-space preload.
    preload_kind = 2;
    @(negedge clk);
    preload_kind = 0;
    send(CH_FF, we_n, la, ld, bn);
    check("ff_busy_cycles", bn, 1200);
    check("ff_writes", we_n, 1200);
    check("ff_last_addr", la, 1199);
    check("ff_cursor_x", int'(cursor_x), 0);
    check("ff_cursor_y", int'(cursor_y), 0);
    bad = 0;
    for (int i = 0; i < 1200; i++) if (tbmem[i] != 8'h20) bad++;
    check("ff_mem_bad", bad, 0);
    $display("FF: busy=%0d writes=%0d bad_cells=%0d cursor=(%0d,%0d)", bn, we_n, bad, cursor_x, cursor_y);

    apply_vec(22);

    // Scroll triggered by LF at (10,29).
    for (int i = 0; i < 29; i++) send(CH_LF, we_n, la, ld, bn);
    check("to_row29_y", int'(cursor_y), 29);
    preload_kind = 1;
    @(negedge clk);
    preload_kind = 0;
    for (int i = 0; i < 10; i++) send(8'h71, we_n, la, ld, bn);
    check("pre_scroll_x", int'(cursor_x), 10);
    check("pre_scroll_y", int'(cursor_y), 29);
    for (int i = 0; i < 1200; i++) snap[i] = tbmem[i];
    send(CH_LF, we_n, la, ld, bn);
    check("scroll_busy_cycles", bn, 2360);
    check("scroll_writes", we_n, 1200);
    check("scroll_cursor_x", int'(cursor_x), 0);
    check("scroll_cursor_y", int'(cursor_y), 29);
    bad = 0;
    for (int i = 0; i < 1160; i++) if (tbmem[i] != snap[i+40]) bad++;
    check("scroll_rows_bad", bad, 0);
    bad = 0;
    for (int i = 1160; i < 1200; i++) if (tbmem[i] != 8'h20) bad++;
    check("scroll_last_row_bad", bad, 0);
    check("scroll_row28_col0", int'(tbmem[1120]), int'(8'h71));
    $display("scroll: busy=%0d writes=%0d cursor=(%0d,%0d)", bn, we_n, cursor_x, cursor_y);

    // clr during the scroll copy at cell 500.
    char_in = CH_LF;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    guard = 0;
    found = 0;
    while (found == 0 && guard < 3000) begin
      if (mem_we && mem_addr == 12'd500) found = 1;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    check("abort_reached_cell500", found, 1);
    clr = 1'b1;
    @(negedge clk);
    check("abort_mem_we", int'(mem_we), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_cursor_x", int'(cursor_x), 0);
    check("abort_cursor_y", int'(cursor_y), 0);
    check("abort_ready_in_clr", int'(char_ready), 0);
    clr = 1'b0;
    #1;
    check("abort_ready_after", int'(char_ready), 1);
    late_we = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we) late_we++;
    end
    check("abort_no_late_writes", late_we, 0);
    $display("abort: reached=%0d cursor=(%0d,%0d) late_writes=%0d", found, cursor_x, cursor_y, late_we);

    apply_vec(23);
    apply_vec(24);

    check("addr_or_cursor_range_errors", range_err, 0);
    check("we_outside_busy", idle_we_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
